aes_request_sequencer: RTL and testbench
========================================

Name: aes_request_sequencer

Overview:
Host-side driver for the AES encrypt/decrypt engine. It accepts one 128-bit operand plus key and mode over a valid/ready request channel, then issues a single-cycle encrypt or decrypt strobe to the engine. It counts a fixed engine latency, captures the engine output and returns it on a valid/ready response channel. It sits between the system bus adapter and the AES engine. It is the only agent that drives the engine strobes, so both strobes are never high together.

Parameters:
LATENCY, 12, cycles from the strobe's falling edge to a stable engine output (must be >= 1)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock
reset  input  1  reset; synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_mode  input  1  0 = encrypt, 1 = decrypt
req_data  input  [0:127]  plaintext (encrypt) or ciphertext (decrypt)
req_key  input  [0:127]  cipher key
eng_encrypt  output  1  encrypt strobe to engine
eng_decrypt  output  1  decrypt strobe to engine
eng_data  output  [0:127]  operand to engine; held stable for the whole operation
eng_key  output  [0:127]  key to engine; held stable for the whole operation
eng_enc_result  input  [0:127]  engine ciphertext output
eng_dec_result  input  [0:127]  engine plaintext output
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_mode  output  1  mode of the returned result
rsp_data  output  [0:127]  result
busy  output  1  high in every state except IDLE
done_count  output  CNT_W  number of responses handed off; wraps modulo 2^CNT_W

Behaviour:
- FSM states: IDLE, STROBE, WAIT, RESP.
- Reset values: state = IDLE. Outputs:
  - eng_encrypt = 0, eng_decrypt = 0
  - eng_data = 0, eng_key = 0
  - rsp_valid = 0, rsp_mode = 0, rsp_data = 0
  - done_count = 0, busy = 0
  - req_ready = 1 in the first cycle after reset.
- req_ready = 1 only in IDLE (combinational from state). There is no request acceptance in RESP, so there is no pipelining.
- IDLE:
  - On an edge where req_valid && req_ready, register req_data into eng_data, req_key into eng_key and req_mode into an internal mode register.
  - Go to STROBE.
- STROBE (exactly 1 cycle):
  - eng_encrypt = (mode == 0); eng_decrypt = (mode == 1). Both are registered outputs.
  - Load the wait counter with 0 and go to WAIT.
  - The strobe is never longer than 1 cycle.
- WAIT:
  - Both strobes are 0. The counter increments each cycle.
  - At the edge where the counter equals LATENCY-1:
    - capture rsp_data = (mode ? eng_dec_result : eng_enc_result);
    - set rsp_mode = mode and rsp_valid = 1;
    - go to RESP.
- Latency: rsp_valid rises exactly LATENCY+1 edges after the accept edge.
- RESP:
  - rsp_valid, rsp_data and rsp_mode are held stable while rsp_ready = 0. Stalling is unbounded.
  - On the edge where rsp_valid && rsp_ready: rsp_valid goes to 0, done_count increments, go to IDLE.
  - A new request is accepted at the earliest on the following edge.
- eng_data and eng_key keep their last values in IDLE. They are not cleared after completion.
- req_* changes while not in IDLE are ignored.
- Reset mid-operation (any state): return to IDLE on that edge with the reset values above. Any in-flight result is discarded and done_count returns to 0.
- Reset on the same edge as a handshake: reset wins, and no accept or count occurs.
- done_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
1. Encrypt, LATENCY=12, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, engine model returns 69c4e0d86a7b0430d8cdb78070b4c55a → eng_encrypt high for exactly 1 cycle, eng_decrypt never high, rsp_valid rises 13 edges after accept, rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_mode = 0, done_count = 1.
2. Decrypt of that ciphertext with the same key, engine model returning 00112233445566778899aabbccddeeff → only eng_decrypt pulses for 1 cycle, rsp_data = 00112233445566778899aabbccddeeff, rsp_mode = 1.
3. Backpressure: hold rsp_ready = 0 for 20 cycles after rsp_valid, keep req_valid = 1 with new data → rsp_data stable, req_ready = 0 throughout, no second strobe; raise rsp_ready → handshake, then the next request is accepted one edge later.
4. Reset asserted in WAIT at counter = 5 → next cycle: state IDLE, rsp_valid = 0, both strobes 0, eng_data = 0, done_count = 0, req_ready = 1, and no late rsp_valid appears.
5. Back-to-back: 3 requests with req_valid held high and rsp_ready tied to 1 → accepts exactly LATENCY+3 edges apart, done_count = 3, strobes never overlap.
6. Wrap: CNT_W = 2, complete 5 operations → done_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/aes_request_sequencer.sv
// aes_request_sequencer: host-side driver for the AES engine.
// Accepts one operand+key+mode per request, pulses a single-cycle encrypt or
// decrypt strobe, waits a fixed engine latency, captures the matching engine
// result and returns it on a valid/ready response channel.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_mode/req_data/req_key  request payload (mode 0 = encrypt, 1 = decrypt)
//   eng_encrypt/eng_decrypt    one-cycle strobes to the engine
//   eng_data/eng_key           operand and key held stable for the engine
//   eng_enc_result/dec_result  engine outputs
//   rsp_valid/rsp_ready        response handshake
//   rsp_mode/rsp_data          response payload
//   busy                       high whenever not idle
//   done_count                 completed handoffs, wraps silently
module aes_request_sequencer #(
    parameter int unsigned LATENCY = 12,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_mode,
    input  logic [0:127]     req_data,
    input  logic [0:127]     req_key,
    output logic             eng_encrypt,
    output logic             eng_decrypt,
    output logic [0:127]     eng_data,
    output logic [0:127]     eng_key,
    input  logic [0:127]     eng_enc_result,
    input  logic [0:127]     eng_dec_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_mode,
    output logic [0:127]     rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    // Wait counter only needs to reach LATENCY-1.
    localparam int unsigned WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mode;
    logic              accept;
    logic              wait_done;
    logic              handoff;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wait_done = 1'b0;
        handoff   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_W'(LATENCY - 1)) begin
                    wait_done = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    handoff   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Datapath: operand latch, strobes, latency counter, result capture.
    // Strobes are set on the accept edge so they are high exactly during STROBE.
    always_ff @(posedge clk) begin
        if (reset) begin
            eng_encrypt <= 1'b0;
            eng_decrypt <= 1'b0;
            eng_data    <= '0;
            eng_key     <= '0;
            mode        <= 1'b0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_mode    <= 1'b0;
            rsp_data    <= '0;
            done_count  <= '0;
        end else begin
            eng_encrypt <= accept && !req_mode;
            eng_decrypt <= accept && req_mode;
            if (accept) begin
                eng_data <= req_data;
                eng_key  <= req_key;
                mode     <= req_mode;
            end
            if (state == STROBE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_done) begin
                rsp_data  <= mode ? eng_dec_result : eng_enc_result;
                rsp_mode  <= mode;
                rsp_valid <= 1'b1;
            end
            if (handoff) begin
                rsp_valid  <= 1'b0;
                done_count <= done_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_request_sequencer.sv
// Self-checking bench for aes_request_sequencer: directed scenarios followed
// by random traffic, checked by a transaction-level model and scoreboard.
module tb_aes_request_sequencer;

    localparam int unsigned LAT = 12;
    localparam int unsigned CW  = 2;

    localparam logic [0:127] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_mode;
    logic [0:127]  req_data;
    logic [0:127]  req_key;
    logic          eng_encrypt;
    logic          eng_decrypt;
    logic [0:127]  eng_data;
    logic [0:127]  eng_key;
    logic [0:127]  eng_enc_result;
    logic [0:127]  eng_dec_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_mode;
    logic [0:127]  rsp_data;
    logic          busy;
    logic [CW-1:0] done_count;

    aes_request_sequencer #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_data(req_data), .req_key(req_key),
        .eng_encrypt(eng_encrypt), .eng_decrypt(eng_decrypt),
        .eng_data(eng_data), .eng_key(eng_key),
        .eng_enc_result(eng_enc_result), .eng_dec_result(eng_dec_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mode(rsp_mode),
        .rsp_data(rsp_data), .busy(busy), .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural engine functions: real AES vectors for the known pair, a toy
    // reversible-looking mix otherwise.
    function automatic logic [0:127] enc_fn(input logic [0:127] d, input logic [0:127] k);
        if (d == PT && k == KEY) return CT;
        return d ^ {k[64:127], k[0:63]} ^ 128'ha5a5a5a5_0f0f0f0f_12345678_9abcdef0;
    endfunction

    function automatic logic [0:127] dec_fn(input logic [0:127] d, input logic [0:127] k);
        if (d == CT && k == KEY) return PT;
        return d ^ k ^ 128'h3c3c3c3c_f0f0f0f0_87654321_0fedcba9;
    endfunction

    typedef struct {
        logic         mode;
        logic [0:127] data;
        logic [0:127] key;
        logic [0:127] rsp;
        int           acc_edge;
    } item_t;

    item_t         sb[$];
    int            acc_log[$];
    int            hand_log[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            cyc = 0;
    bit            outstanding = 0;
    bit            strobe_due = 0;
    bit            prev_rst = 0;
    bit            exp_rv;
    logic [CW-1:0] exp_cnt = '0;
    int            n_enc = 0;
    int            n_dec = 0;
    int            eng_age = 1000;
    logic [0:127]  eng_e_val = '0;
    logic [0:127]  eng_d_val = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + model: check what the last edge produced, then decide what the
    // coming edge will do from the currently driven inputs.
    always @(negedge clk) begin
        exp_rv = outstanding && (sb.size() > 0) && (cyc >= sb[0].acc_edge + int'(LAT) + 1);
        if (cyc > 0) begin
            if (prev_rst) begin
                chk("rst_rsp_mode", 128'(rsp_mode), 128'(0));
                chk("rst_rsp_data", rsp_data, 128'(0));
                chk("rst_eng_data", eng_data, 128'(0));
                chk("rst_eng_key",  eng_key,  128'(0));
            end
            chk("req_ready",  128'(req_ready), 128'(!outstanding));
            chk("busy",       128'(busy),      128'(outstanding));
            chk("done_count", 128'(done_count), 128'(exp_cnt));
            if (strobe_due)
                chk("strobes", 128'({eng_encrypt, eng_decrypt}), 128'({!sb[0].mode, sb[0].mode}));
            else
                chk("strobes_idle", 128'({eng_encrypt, eng_decrypt}), 128'(0));
            chk("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
            if (exp_rv) begin
                chk("rsp_data", rsp_data, sb[0].rsp);
                chk("rsp_mode", 128'(rsp_mode), 128'(sb[0].mode));
            end
            if (outstanding) begin
                chk("eng_data", eng_data, sb[0].data);
                chk("eng_key",  eng_key,  sb[0].key);
            end
            if (eng_encrypt) n_enc++;
            if (eng_decrypt) n_dec++;
        end

        // Engine model: output only becomes valid LAT edges after the strobe falls.
        if (eng_encrypt === 1'b1 || eng_decrypt === 1'b1) begin
            eng_age   = 0;
            eng_e_val = enc_fn(eng_data, eng_key);
            eng_d_val = dec_fn(eng_data, eng_key);
        end else if (eng_age < 1000) begin
            eng_age++;
        end
        eng_enc_result = (eng_age >= int'(LAT)) ? eng_e_val : ~eng_e_val;
        eng_dec_result = (eng_age >= int'(LAT)) ? eng_d_val : ~eng_d_val;

        strobe_due = 0;
        prev_rst   = 0;
        if (reset) begin
            sb.delete();
            outstanding = 0;
            exp_cnt     = '0;
            prev_rst    = 1;
        end else if (exp_rv && rsp_ready) begin
            void'(sb.pop_front());
            outstanding = 0;
            exp_cnt     = exp_cnt + 1'b1;
            hand_log.push_back(cyc + 1);
        end else if (!outstanding && req_valid) begin
            item_t it;
            it.mode     = req_mode;
            it.data     = req_data;
            it.key      = req_key;
            it.rsp      = req_mode ? dec_fn(req_data, req_key) : enc_fn(req_data, req_key);
            it.acc_edge = cyc + 1;
            sb.push_back(it);
            outstanding = 1;
            strobe_due  = 1;
            acc_log.push_back(cyc + 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic m, input logic [0:127] d, input logic [0:127] k);
        int n0;
        bit ok;
        n0 = acc_log.size();
        ok = 0;
        req_valid = 1'b1;
        req_mode  = m;
        req_data  = d;
        req_key   = k;
        for (int i = 0; i < 200; i++) begin
            step();
            if (acc_log.size() > n0) begin
                ok = 1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!ok) chk("send_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!outstanding) return;
            step();
        end
        chk("idle_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        int e0;
        int d0;
        int a0;
        bit seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_mode  = 1'b0;
        req_data  = '0;
        req_key   = '0;
        rsp_ready = 1'b0;
        eng_enc_result = '0;
        eng_dec_result = '0;
        repeat (3) step();
        reset = 1'b0;

        // Known-answer encrypt then decrypt.
        rsp_ready = 1'b1;
        e0 = n_enc; d0 = n_dec;
        send(1'b0, PT, KEY);
        wait_idle();
        chk("t1_enc_pulses", 128'(n_enc - e0), 128'(1));
        chk("t1_dec_pulses", 128'(n_dec - d0), 128'(0));
        chk("t1_done", 128'(done_count), 128'(1));
        e0 = n_enc; d0 = n_dec;
        send(1'b1, CT, KEY);
        wait_idle();
        chk("t2_enc_pulses", 128'(n_enc - e0), 128'(0));
        chk("t2_dec_pulses", 128'(n_dec - d0), 128'(1));
        chk("t2_done", 128'(done_count), 128'(2));

        // Backpressure with a pending request held on the bus.
        rsp_ready = 1'b0;
        e0 = n_enc + n_dec;
        send(1'b0, rnd128(), rnd128());
        req_valid = 1'b1;
        req_mode  = 1'b1;
        req_data  = rnd128();
        req_key   = rnd128();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid === 1'b1) begin
                seen = 1;
                break;
            end
            step();
        end
        chk("t3_rsp_seen", 128'(seen), 128'(1));
        repeat (20) step();
        chk("t3_single_strobe", 128'(n_enc + n_dec - e0), 128'(1));
        a0 = acc_log.size();
        rsp_ready = 1'b1;
        step();
        step();
        req_valid = 1'b0;
        chk("t3_accepts", 128'(acc_log.size() - a0), 128'(1));
        chk("t3_accept_after_handoff", 128'(acc_log[$] - hand_log[$]), 128'(1));
        wait_idle();

        // Reset while waiting, counter at 5.
        send(1'b0, rnd128(), rnd128());
        repeat (6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_done", 128'(done_count), 128'(0));
        chk("t4_ready", 128'(req_ready), 128'(1));
        repeat (20) step();

        // Back-to-back requests.
        rsp_ready = 1'b1;
        a0 = acc_log.size();
        req_valid = 1'b1;
        req_mode  = 1'b0;
        req_data  = rnd128();
        req_key   = rnd128();
        for (int i = 0; i < 200 && acc_log.size() < a0 + 3; i++) step();
        req_valid = 1'b0;
        wait_idle();
        chk("t5_accepts", 128'(acc_log.size() - a0), 128'(3));
        if (acc_log.size() >= a0 + 3) begin
            chk("t5_gap1", 128'(acc_log[a0 + 1] - acc_log[a0]), 128'(LAT + 3));
            chk("t5_gap2", 128'(acc_log[a0 + 2] - acc_log[a0 + 1]), 128'(LAT + 3));
        end
        chk("t5_done", 128'(done_count), 128'(3));

        // Counter wrap with a 2-bit counter.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(1'($urandom_range(0, 1)), rnd128(), rnd128());
            wait_idle();
            chk("t6_wrap", 128'(done_count), 128'((i + 1) % 4));
        end

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_mode  = 1'($urandom_range(0, 1));
            req_data  = rnd128();
            req_key   = rnd128();
            rsp_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
